// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT circular FIFO with occupancy, sticky overflow and saturating error count.
// Data appears one edge after push; full+push without pop drops the byte. Build option: UART_RX_ERR_TAG_EN.
module uart_rx_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DATA_WIDTH-1:0]      i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_rx_error,
    output logic [DATA_WIDTH-1:0]      o_rd_data,
    output logic                       o_rd_error,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_overflow,
    input  logic                       i_clr_overflow,
    output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef UART_RX_ERR_TAG_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               storable;
    logic               push_try;
    logic               push;
    logic               pop;
    logic               drop;

`ifdef UART_RX_ERR_TAG_EN
    assign storable   = 1'b1;
    assign wr_entry   = {i_rx_error, i_rx_data};
    assign o_rd_error = head[DATA_WIDTH];
`else
    // Errored bytes never reach storage in this build, so they cannot overflow either.
    assign storable   = ~i_rx_error;
    assign wr_entry   = i_rx_data;
    assign o_rd_error = 1'b0;
`endif

    assign head       = mem[rd_ptr];
    assign o_rd_data  = head[DATA_WIDTH-1:0];
    assign o_rd_valid = (o_count != '0);
    assign o_full     = (o_count == CNT_W'(DEPTH));

    assign push_try = i_rx_valid & storable;
    assign pop      = o_rd_valid & i_rd_ready;
    assign push     = push_try & (~o_full | pop);
    assign drop     = push_try & o_full & ~pop;

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                o_overflow <= 1'b0;
            end
            if (i_rx_valid && i_rx_error && !(&o_err_cnt)) begin
                o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of expected head entries.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int EW    = 8;
`ifdef UART_RX_ERR_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [DW-1:0] i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic          i_rx_error = 1'b0;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_error;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b0;
    logic [4:0]    o_count;
    logic          o_full;
    logic          o_overflow;
    logic          i_clr_overflow = 1'b0;
    logic [EW-1:0] o_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    logic [DW:0] sb [$];

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ERR_CNT_WIDTH(EW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_rx_error(i_rx_error), .o_rd_data(o_rd_data), .o_rd_error(o_rd_error),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_count(o_count), .o_full(o_full),
        .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input logic err);
        i_rx_data  = d;
        i_rx_error = err;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_error = 1'b0;
    endtask

    task automatic drain(input int n);
        i_rd_ready = 1'b1;
        repeat (n) tick();
        i_rd_ready = 1'b0;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so decide here what the next rising edge does.
    always @(negedge i_clk) begin
        bit m_pop;
        int pre;
        if (i_rst) begin
            sb.delete();
        end else if (mon_en) begin
            pre = sb.size();
            check("count_vs_model", o_count, pre);
            check("valid_vs_model", o_rd_valid, pre != 0);
            m_pop = (pre != 0) && i_rd_ready;
            if (m_pop) begin
                check("head_data", o_rd_data, sb[0][DW-1:0]);
                check("head_error", o_rd_error, sb[0][DW]);
                void'(sb.pop_front());
            end
            if (i_rx_valid && (TAG_EN || !i_rx_error)) begin
                if (pre < DEPTH || m_pop) sb.push_back({TAG_EN & i_rx_error, i_rx_data});
            end
        end
    end

    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("rst_count", o_count, 0);
        check("rst_valid", o_rd_valid, 0);
        check("rst_full", o_full, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        mon_en = 1'b1;

        // Basic ordering with host stalled, then streaming reads.
        push_byte(8'h41, 1'b0);
        push_byte(8'h42, 1'b0);
        push_byte(8'h43, 1'b0);
        check("three_count", o_count, 3);
        check("three_head", o_rd_data, 8'h41);
        drain(3);
        check("three_empty", o_rd_valid, 0);

        // Fill, overflow drop, drain, clear.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
        check("fill_full", o_full, 1);
        check("fill_no_ovf", o_overflow, 0);
        push_byte(8'hAA, 1'b0);
        check("ovf_full", o_full, 1);
        check("ovf_flag", o_overflow, 1);
        check("ovf_count", o_count, 16);
        drain(DEPTH);
        check("ovf_drained", o_rd_valid, 0);
        check("ovf_sticky", o_overflow, 1);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        check("ovf_cleared", o_overflow, 0);

        // Full with simultaneous push and pop: no overflow, count holds.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i), 1'b0);
        i_rd_ready = 1'b1;
        push_byte(8'h55, 1'b0);
        check("pp_no_ovf", o_overflow, 0);
        check("pp_count", o_count, 16);
        repeat (DEPTH) tick();
        i_rd_ready = 1'b0;
        check("pp_empty", o_rd_valid, 0);

        // Drop and clear on the same edge: set wins.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i), 1'b0);
        i_clr_overflow = 1'b1;
        push_byte(8'h66, 1'b0);
        i_clr_overflow = 1'b0;
        check("set_wins", o_overflow, 1);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        check("clr_again", o_overflow, 0);
        drain(DEPTH);

        // Errored byte.
        push_byte(8'h7E, 1'b1);
        check("err_cnt_one", o_err_cnt, 1);
        if (TAG_EN) begin
            check("err_tag_data", o_rd_data, 8'h7E);
            check("err_tag_flag", o_rd_error, 1);
        end else begin
            check("err_nostore_count", o_count, 0);
            check("err_nostore_valid", o_rd_valid, 0);
        end
        drain(1);

        // Saturation of the error counter (301 total errored strobes).
        i_rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_byte(8'(i), 1'b1);
        tick();
        i_rd_ready = 1'b0;
        check("err_cnt_sat", o_err_cnt, 255);
        check("sat_no_ovf", o_overflow, 0);

        // Reset mid-stream with overflow set and five bytes held.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h30 + i), 1'b0);
        push_byte(8'hBB, 1'b0);
        drain(11);
        check("pre_rst_count", o_count, 5);
        check("pre_rst_ovf", o_overflow, 1);
        i_rst = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data = 8'h99;
        i_rd_ready = 1'b1;
        tick();
        i_rst = 1'b0;
        i_rx_valid = 1'b0;
        i_rd_ready = 1'b0;
        check("mid_rst_count", o_count, 0);
        check("mid_rst_valid", o_rd_valid, 0);
        check("mid_rst_err_cnt", o_err_cnt, 0);
        check("mid_rst_ovf", o_overflow, 0);
        check("mid_rst_full", o_full, 0);

        // 40 pushes with occupancy oscillating 2..3 so pointers wrap twice.
        push_byte(8'($urandom), 1'b0);
        push_byte(8'($urandom), 1'b0);
        for (int i = 0; i < 19; i++) begin
            i_rd_ready = 1'b1;
            push_byte(8'($urandom), 1'b0);
            i_rd_ready = 1'b0;
            push_byte(8'($urandom), 1'b0);
            drain(1);
        end
        drain(3);
        check("wrap_empty", o_rd_valid, 0);
        check("wrap_count", o_count, 0);
        check("wrap_no_ovf", o_overflow, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
